// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V front end.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs. Synchronous active-low reset.
// flush empties the FIFO and wins over a push in the same cycle.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  // Head reads as zero when empty so downstream never sees stale data.
  assign head = (count != '0) ? mem[rd_ptr] : '0;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: sequential PC generation, in-order memory
// requests, prefetch buffering and redirect with stale-response dropping.
module riscv_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 4,
  parameter int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   in_use;
  logic [XLEN-1:0]  target_pc;
  logic             req_fire;
  logic             dropping;
  logic             keep;
  logic             pop;
  fetch_entry_t     head;

  // Buffered plus in-flight fetches never exceed the FIFO size, so every
  // response always has a free slot.
  assign in_use          = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid  = rst && (in_use < DEPTH_EXT);
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

  assign target_pc = align_pc(redirect_pc);
  assign dropping  = (drop_cnt != '0);
  assign keep      = imem_resp_valid && !redirect_valid && !dropping;

  assign out_valid = rst && (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  // PC, in-flight and stale-response bookkeeping. On redirect everything
  // still in flight (including a request accepted this cycle) is stale.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire)                    fetch_pc <= fetch_pc + PC_STEP;
        if (imem_resp_valid && dropping) drop_cnt <= drop_cnt - CNT_W'(1);
        if (keep)                        resp_pc  <= resp_pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (keep),
    .push_data ('{pc: resp_pc, instr: imem_resp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch with an in-order memory model that
// returns the bitwise inverse of the requested address.
module tb_riscv_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  int cyc      = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;
  pend_t pend[$];

  riscv_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
  );

  riscv_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (w_req_valid),
    .imem_req_ready  (w_req_ready),
    .imem_req_addr   (w_req_addr),
    .imem_resp_valid (w_resp_valid),
    .imem_resp_data  (w_resp_data),
    .redirect_valid  (w_redirect_valid),
    .redirect_pc     (w_redirect_pc),
    .out_valid       (w_out_valid),
    .out_ready       (w_out_ready),
    .out_instr       (w_out_instr),
    .out_pc          (w_out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: records accepted requests mid-cycle, answers in order
  // mem_lat cycles later; cleared whenever reset is held.
  always @(negedge clk) begin
    if (!rst) begin
      pend.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = ~pend[0].addr;
        void'(pend.pop_front());
        n_checks++;
        if (dut.outstanding == 0) begin
          n_fail++;
          $display("FAIL resp_protocol: response with outstanding=%0d, required nonzero", dut.outstanding);
        end
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end
      if (imem_req_valid && imem_req_ready) pend.push_back('{cyc + mem_lat, imem_req_addr});
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    w_req_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    n_checks++;
    if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data: got pc=%h instr=%h expected 0/0", out_pc, out_instr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_first_req: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    do_reset();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * i)) begin
        n_fail++; $display("FAIL seq_req c%0d: got valid=%b addr=%h expected 1/%h", i, imem_req_valid, imem_req_addr, 32'(4 * i));
      end
      n_checks++;
      if (out_valid !== (i >= 2)) begin
        n_fail++; $display("FAIL seq_out_valid c%0d: got %b expected %b", i, out_valid, (i >= 2));
      end
      if (i >= 2) begin
        e = 32'(4 * (i - 2));
        n_checks++;
        if (out_pc !== e || out_instr !== ~e) begin
          n_fail++; $display("FAIL seq_out c%0d: got pc=%h instr=%h expected %h/%h", i, out_pc, out_instr, e, ~e);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    logic [31:0] e;
    do_reset();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (imem_req_valid) fires++;
      if (c >= 4) begin
        n_checks++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_stall c%0d: got req_valid=%b expected 0", c, imem_req_valid); end
      end
      if (c >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
          n_fail++; $display("FAIL bp_hold c%0d: got valid=%b pc=%h expected 1/00000000", c, out_valid, out_pc);
        end
      end
      tick();
    end
    n_checks++;
    if (fires != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d requests expected 4", fires); end
    out_ready = 1'b1;
    for (int c = 8; c < 14; c++) begin
      e = 32'(4 * (c - 8));
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== e || out_instr !== ~e) begin
        n_fail++; $display("FAIL bp_drain c%0d: got valid=%b pc=%h instr=%h expected 1/%h/%h", c, out_valid, out_pc, out_instr, e, ~e);
      end
      if (c == 8) begin
        n_checks++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_full_c8: got req_valid=%b expected 0", imem_req_valid); end
      end
      if (c == 9) begin
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
          n_fail++; $display("FAIL bp_resume: got valid=%b addr=%h expected 1/00000010", imem_req_valid, imem_req_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] e;
    do_reset();
    mem_lat = 3;
    out_ready = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    tick();
    imem_req_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL redir_pre: got valid=%b pc=%h expected 1/00000000", out_valid, out_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_req: got valid=%b addr=%h expected 1/00000100", imem_req_valid, imem_req_addr);
    end
    for (int c = 6; c < 10; c++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop c%0d: got valid=%b pc=%h expected 0", c, out_valid, out_pc); end
      tick();
    end
    for (int c = 10; c < 13; c++) begin
      e = 32'h100 + 32'(4 * (c - 10));
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== e || out_instr !== ~e) begin
        n_fail++; $display("FAIL redir_out c%0d: got valid=%b pc=%h instr=%h expected 1/%h/%h", c, out_valid, out_pc, out_instr, e, ~e);
      end
      tick();
    end
  endtask

  task automatic test_redirect_collision();
    do_reset();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      n_fail++; $display("FAIL coll_req: got valid=%b addr=%h expected 1/00000200", imem_req_valid, imem_req_addr);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_drop_c2: got valid=%b pc=%h expected 0", out_valid, out_pc); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL coll_drop_c3: got valid=%b pc=%h expected 0", out_valid, out_pc); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instr !== ~32'h200) begin
      n_fail++; $display("FAIL coll_first: got valid=%b pc=%h instr=%h expected 1/00000200/fffffdff", out_valid, out_pc, out_instr);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h204) begin
      n_fail++; $display("FAIL coll_second: got valid=%b pc=%h expected 1/00000204", out_valid, out_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_lat = 1;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_pc = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_req_addr !== 32'h400) begin n_fail++; $display("FAIL b2b_req: got addr=%h expected 00000400", imem_req_addr); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop_c3: got valid=%b pc=%h expected 0", out_valid, out_pc); end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop_c4: got valid=%b pc=%h expected 0", out_valid, out_pc); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h400 || out_instr !== ~32'h400) begin
      n_fail++; $display("FAIL b2b_first: got valid=%b pc=%h instr=%h expected 1/00000400/fffffbff", out_valid, out_pc, out_instr);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h404) begin
      n_fail++; $display("FAIL b2b_second: got valid=%b pc=%h expected 1/00000404", out_valid, out_pc);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    mem_lat = 2;
    imem_req_ready = 1'b1;
    out_ready = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || dut.outstanding !== 3'd2 || dut.u_fifo.count !== 3'd2) begin
      n_fail++; $display("FAIL mid_setup: got valid=%b pc=%h outstanding=%0d count=%0d expected 1/0/2/2",
                         out_valid, out_pc, dut.outstanding, dut.u_fifo.count);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_now: got out_valid=%b req_valid=%b expected 0/0", out_valid, imem_req_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || dut.u_fifo.count !== 3'd0 || dut.outstanding !== 3'd0) begin
      n_fail++; $display("FAIL mid_rst_next: got valid=%b count=%0d outstanding=%0d expected 0/0/0",
                         out_valid, dut.u_fifo.count, dut.outstanding);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_restart: got valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
    end
    repeat (3) tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mid_first_out: got valid=%b pc=%h instr=%h expected 1/00000000/ffffffff", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'hFFFF_FFF8;
    exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000;
    exp_addr[3] = 32'h0000_0004;
    do_reset();
    w_req_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        n_checks++;
        if (w_req_valid !== 1'b1 || w_req_addr !== exp_addr[c]) begin
          n_fail++; $display("FAIL wrap_req c%0d: got valid=%b addr=%h expected 1/%h", c, w_req_valid, w_req_addr, exp_addr[c]);
        end
      end else begin
        n_checks++;
        if (w_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_cap c%0d: got valid=%b expected 0", c, w_req_valid); end
      end
      tick();
    end
    w_req_ready = 1'b0;
    n_checks++;
    if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_out_valid: got %b expected 0", w_out_valid); end
  endtask

  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    w_req_ready = 1'b0;
    w_resp_valid = 1'b0;
    w_resp_data = 32'h0;
    w_redirect_valid = 1'b0;
    w_redirect_pc = 32'h0;
    w_out_ready = 1'b0;
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_collision();
    test_back_to_back();
    test_reset_midop();
    test_reset_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
